// File: rtl/lupdate_pkg.sv
// Shared definitions for the beacon-update consumer: word-type encodings,
// word indices, field positions inside the 134-bit stream word and FSM states.
package lupdate_pkg;

  localparam int WORD_W = 134;

  // Word-type field [133:132]
  localparam int TYPE_HI = 133;
  localparam int TYPE_LO = 132;
  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] MID  = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  // Word-index counter saturates at IDX_MAX; only indices up to 6 matter
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] IDX_ETH    = 3'd2;
  localparam logic [IDX_W-1:0] IDX_BEACON = 3'd6;
  localparam logic [IDX_W-1:0] IDX_MAX    = 3'd7;

  // Word 2: Ethernet header and PTP messageType
  localparam int DMAC_HI  = 127;
  localparam int DMAC_LO  = 80;
  localparam int ETH_HI   = 31;
  localparam int ETH_LO   = 16;
  localparam int MTYPE_HI = 11;
  localparam int MTYPE_LO = 8;

  // Word 6: beacon update payload
  localparam int BMAC_HI  = 127;
  localparam int BMAC_LO  = 80;
  localparam int BDIR_BIT = 79;
  localparam int BTOK_HI  = 63;
  localparam int BTOK_LO  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // A word closes its packet if it is a tail, or if it carries valid_wr
  // (a single-word packet is a head word that also carries valid_wr).
  function automatic logic word_is_eop(input logic [1:0] wtype, input logic valid_wr);
    return (wtype == TAIL) || valid_wr;
  endfunction

endpackage

// File: rtl/lupdate_pipe.sv
// Two-stage shift register for the packet stream plus the input word-index
// counter. Words that do not belong to a packet opened by a head (for example
// the remainder of a packet cut short by reset) enter the pipe with wr cleared.
module lupdate_pipe
  import lupdate_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_wr_i,
  input  logic [WORD_W-1:0] in_data_i,
  input  logic              in_valid_i,
  input  logic              in_valid_wr_i,
  output logic              in_pkt_o,
  output logic              in_head_o,
  output logic [IDX_W-1:0]  in_idx_o,
  output logic              s2_wr_o,
  output logic [WORD_W-1:0] s2_data_o,
  output logic              s2_valid_o,
  output logic              s2_valid_wr_o,
  output logic [IDX_W-1:0]  s2_idx_o
);

  logic             active_q;
  logic [IDX_W-1:0] idx_q;

  logic              s1_wr_q;
  logic [WORD_W-1:0] s1_data_q;
  logic              s1_valid_q;
  logic              s1_valid_wr_q;
  logic [IDX_W-1:0]  s1_idx_q;

  logic              s2_wr_q;
  logic [WORD_W-1:0] s2_data_q;
  logic              s2_valid_q;
  logic              s2_valid_wr_q;
  logic [IDX_W-1:0]  s2_idx_q;

  logic             in_head;
  logic             in_pkt;
  logic             in_eop;
  logic [IDX_W-1:0] in_idx;

  // Decode the word currently on the input: head, packet membership, index
  always_comb begin
    in_head = in_wr_i && (in_data_i[TYPE_HI:TYPE_LO] == HEAD);
    in_pkt  = in_head || (in_wr_i && active_q);
    in_idx  = in_head ? '0 : idx_q;
    in_eop  = in_pkt && word_is_eop(in_data_i[TYPE_HI:TYPE_LO], in_valid_wr_i);
  end

  // Word counter: restarts at every head, stops tracking after end of packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      idx_q    <= '0;
    end else if (in_pkt) begin
      active_q <= !in_eop;
      idx_q    <= (in_idx == IDX_MAX) ? IDX_MAX : in_idx + 3'd1;
    end
  end

  // Stream shift register s1 -> s2, advancing every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_wr_q       <= 1'b0;
      s1_data_q     <= '0;
      s1_valid_q    <= 1'b0;
      s1_valid_wr_q <= 1'b0;
      s1_idx_q      <= '0;
      s2_wr_q       <= 1'b0;
      s2_data_q     <= '0;
      s2_valid_q    <= 1'b0;
      s2_valid_wr_q <= 1'b0;
      s2_idx_q      <= '0;
    end else begin
      s1_wr_q       <= in_pkt;
      s1_data_q     <= in_data_i;
      s1_valid_q    <= in_pkt && in_valid_i;
      s1_valid_wr_q <= in_pkt && in_valid_wr_i;
      s1_idx_q      <= in_idx;
      s2_wr_q       <= s1_wr_q;
      s2_data_q     <= s1_data_q;
      s2_valid_q    <= s1_valid_q;
      s2_valid_wr_q <= s1_valid_wr_q;
      s2_idx_q      <= s1_idx_q;
    end
  end

  assign in_pkt_o      = in_pkt;
  assign in_head_o     = in_head;
  assign in_idx_o      = in_idx;
  assign s2_wr_o       = s2_wr_q;
  assign s2_data_o     = s2_data_q;
  assign s2_valid_o    = s2_valid_q;
  assign s2_valid_wr_o = s2_valid_wr_q;
  assign s2_idx_o      = s2_idx_q;

endmodule

// File: rtl/lupdate.sv
// Beacon-update consumer. Classifies each packet when its head reaches s2
// (word 2 is then on the input), drops beacon updates addressed to this node
// and commits their word-6 parameters; everything else leaves 3 cycles later.
module lupdate
  import lupdate_pkg::*;
#(
  parameter logic [15:0] PTP_ETHERTYPE   = 16'h88F7,
  parameter logic [3:0]  UPDATE_MSG_TYPE = 4'hD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_lu_data_wr,
  input  logic [WORD_W-1:0] in_lu_data,
  input  logic              in_lu_data_valid,
  input  logic              in_lu_data_valid_wr,
  input  logic [47:0]       in_local_mac_id,
  output logic              out_lu_data_wr,
  output logic [WORD_W-1:0] out_lu_data,
  output logic              out_lu_data_valid,
  output logic              out_lu_data_valid_wr,
  output logic              beacon_update_master,
  output logic              direction,
  output logic [31:0]       token_bucket_para,
  output logic [47:0]       direct_mac_addr,
  output logic [63:0]       lupdate_cnt
);

  logic              in_pkt;
  logic              in_head;
  logic [IDX_W-1:0]  in_idx;
  logic              s2_wr;
  logic [WORD_W-1:0] s2_data;
  logic              s2_valid;
  logic              s2_valid_wr;
  logic [IDX_W-1:0]  s2_idx;

  lupdate_pipe u_pipe (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_wr_i       (in_lu_data_wr),
    .in_data_i     (in_lu_data),
    .in_valid_i    (in_lu_data_valid),
    .in_valid_wr_i (in_lu_data_valid_wr),
    .in_pkt_o      (in_pkt),
    .in_head_o     (in_head),
    .in_idx_o      (in_idx),
    .s2_wr_o       (s2_wr),
    .s2_data_o     (s2_data),
    .s2_valid_o    (s2_valid),
    .s2_valid_wr_o (s2_valid_wr),
    .s2_idx_o      (s2_idx)
  );

  state_e state_q;
  state_e state_d;

  logic        s2_head;
  logic        s2_eop;
  logic        is_update;
  logic        drop_now;
  logic        commit_now;

  logic [47:0] sh_mac_q;
  logic        sh_dir_q;
  logic [31:0] sh_tok_q;

  // Classification, drop decision, next state and commit condition
  always_comb begin
    s2_head = s2_wr && (s2_data[TYPE_HI:TYPE_LO] == HEAD);
    s2_eop  = s2_wr && word_is_eop(s2_data[TYPE_HI:TYPE_LO], s2_valid_wr);
    // With no gaps inside a packet, a non-head word at index 2 on the input
    // while a head sits in s2 is word 2 of that same packet.
    is_update = in_pkt && !in_head && (in_idx == IDX_ETH) &&
                (in_lu_data[DMAC_HI:DMAC_LO] == in_local_mac_id) &&
                (in_lu_data[ETH_HI:ETH_LO] == PTP_ETHERTYPE) &&
                (in_lu_data[MTYPE_HI:MTYPE_LO] == UPDATE_MSG_TYPE);
    // The head itself leaves s2 in the classification cycle, so it takes the
    // fresh decision; later words follow the latched state.
    drop_now = s2_head ? is_update : (state_q == ST_DROP);
    state_d  = state_q;
    if (s2_head) begin
      state_d = is_update ? ST_DROP : ST_FWD;
    end
    if (s2_eop) begin
      state_d = ST_IDLE;
    end
    // Tail index >= 6 means word 6 of this packet passed the input and the
    // shadow registers hold its fields.
    commit_now = drop_now && s2_eop && (s2_idx >= IDX_BEACON) &&
                 s2_valid_wr && s2_valid;
  end

  // Shadow copy of the beacon fields while word 6 is on the input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_mac_q <= '0;
      sh_dir_q <= 1'b0;
      sh_tok_q <= '0;
    end else if (in_pkt && !in_head && (in_idx == IDX_BEACON)) begin
      sh_mac_q <= in_lu_data[BMAC_HI:BMAC_LO];
      sh_dir_q <= in_lu_data[BDIR_BIT];
      sh_tok_q <= in_lu_data[BTOK_HI:BTOK_LO];
    end
  end

  // FSM, output register stage and commit of the beacon parameters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= ST_IDLE;
      out_lu_data_wr       <= 1'b0;
      out_lu_data          <= '0;
      out_lu_data_valid    <= 1'b0;
      out_lu_data_valid_wr <= 1'b0;
      beacon_update_master <= 1'b0;
      direction            <= 1'b0;
      token_bucket_para    <= '0;
      direct_mac_addr      <= '0;
      lupdate_cnt          <= '0;
    end else begin
      state_q <= state_d;
      if (drop_now) begin
        out_lu_data_wr       <= 1'b0;
        out_lu_data          <= '0;
        out_lu_data_valid    <= 1'b0;
        out_lu_data_valid_wr <= 1'b0;
      end else begin
        out_lu_data_wr       <= s2_wr;
        out_lu_data          <= s2_data;
        out_lu_data_valid    <= s2_valid;
        out_lu_data_valid_wr <= s2_valid_wr;
      end
      if (commit_now) begin
        direction            <= sh_dir_q;
        token_bucket_para    <= sh_tok_q;
        direct_mac_addr      <= sh_mac_q;
        beacon_update_master <= ~beacon_update_master;
        lupdate_cnt          <= lupdate_cnt + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_lupdate.sv
// Directed bench for lupdate: forwarded packets are expected 3 cycles after
// they are driven, dropped packets leave zeros, beacon registers are checked
// against hand-written values one cycle before and at tail+3.
module tb_lupdate;
  import lupdate_pkg::*;

  localparam logic [47:0] LOCAL_MAC = 48'h0011_2233_4455;
  localparam logic [47:0] OTHER_MAC = 48'h0066_7788_99AA;
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_wr = 1'b0;
  logic [133:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_vwr = 1'b0;
  logic         out_wr;
  logic [133:0] out_data;
  logic         out_valid;
  logic         out_vwr;
  logic         master;
  logic         dir;
  logic [31:0]  tok;
  logic [47:0]  dmac_out;
  logic [63:0]  cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [136:0] exp_out [0:1023];

  always #5 clk = ~clk;

  lupdate dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_lu_data_wr        (in_wr),
    .in_lu_data           (in_data),
    .in_lu_data_valid     (in_valid),
    .in_lu_data_valid_wr  (in_vwr),
    .in_local_mac_id      (LOCAL_MAC),
    .out_lu_data_wr       (out_wr),
    .out_lu_data          (out_data),
    .out_lu_data_valid    (out_valid),
    .out_lu_data_valid_wr (out_vwr),
    .beacon_update_master (master),
    .direction            (dir),
    .token_bucket_para    (tok),
    .direct_mac_addr      (dmac_out),
    .lupdate_cnt          (cnt)
  );

  task automatic chk(input string tag, input logic [136:0] got, input logic [136:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge, check the stream.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    chk("out", {out_wr, out_valid, out_vwr, out_data}, exp_out[cyc]);
  endtask

  task automatic chk_regs(input string tag, input logic e_dir, input logic [31:0] e_tok,
                          input logic [47:0] e_mac, input logic e_master, input logic [63:0] e_cnt);
    chk({tag, ".direction"}, 137'(dir), 137'(e_dir));
    chk({tag, ".token"}, 137'(tok), 137'(e_tok));
    chk({tag, ".direct_mac"}, 137'(dmac_out), 137'(e_mac));
    chk({tag, ".master"}, 137'(master), 137'(e_master));
    chk({tag, ".cnt"}, 137'(cnt), 137'(e_cnt));
  endtask

  function automatic logic [133:0] build_word(input int i, input int n, input logic [47:0] dmac,
                                              input logic [15:0] eth, input logic [3:0] mt,
                                              input logic bdir, input logic [31:0] btok,
                                              input logic [47:0] bmac, input logic [7:0] id);
    logic [1:0]   t;
    logic [127:0] p;
    t = (i == 0) ? HEAD : ((i == n - 1) ? TAIL : MID);
    p = {id, 8'(i), {14{8'h5A}}};
    if (i == 2) p = {dmac, 48'h02AB_CDEF_0001, eth, 4'h0, mt, id};
    if (i == 6) p = {bmac, bdir, 15'h0, btok, 32'h0};
    return {t, 4'h0, p};
  endfunction

  task automatic drive(input logic [133:0] w, input logic v, input logic vwr, input bit fwd);
    in_wr    = 1'b1;
    in_data  = w;
    in_valid = v;
    in_vwr   = vwr;
    if (fwd) exp_out[cyc + 3] = {1'b1, v, vwr, w};
    step();
  endtask

  task automatic idle(input int n);
    in_wr    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    in_vwr   = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_pkt(input int n, input logic [47:0] dmac, input logic [3:0] mt,
                          input logic bdir, input logic [31:0] btok, input logic [47:0] bmac,
                          input logic tail_valid, input bit fwd, input logic [7:0] id);
    for (int i = 0; i < n; i++) begin
      drive(build_word(i, n, dmac, 16'h88F7, mt, bdir, btok, bmac, id),
            (i == n - 1) ? tail_valid : 1'b0, (i == n - 1), fwd);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) exp_out[i] = '0;

    // Reset state
    idle(3);
    chk_regs("reset", 1'b0, 32'h0, 48'h0, 1'b0, 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Plain 4-word forwarded packet, tail valid=1
    send_pkt(4, BCAST_MAC, 4'h0, 1'b0, 32'h0, 48'h0, 1'b1, 1'b1, 8'h01);
    idle(5);
    chk_regs("fwd4", 1'b0, 32'h0, 48'h0, 1'b0, 64'd0);

    // Good 7-word update: dropped, commits at tail+3
    send_pkt(7, LOCAL_MAC, 4'hD, 1'b1, 32'h0000_1234, 48'hA1B2C3D4E5F6, 1'b1, 1'b0, 8'h02);
    idle(1);
    chk_regs("upd1_pre", 1'b0, 32'h0, 48'h0, 1'b0, 64'd0);
    idle(1);
    chk_regs("upd1", 1'b1, 32'h0000_1234, 48'hA1B2C3D4E5F6, 1'b1, 64'd1);
    idle(4);

    // Update with tail valid=0, then a truncated 5-word update: both dropped, no commit
    send_pkt(7, LOCAL_MAC, 4'hD, 1'b0, 32'h0000_5555, 48'h112233445566, 1'b0, 1'b0, 8'h03);
    idle(5);
    chk_regs("upd_bad", 1'b1, 32'h0000_1234, 48'hA1B2C3D4E5F6, 1'b1, 64'd1);
    send_pkt(5, LOCAL_MAC, 4'hD, 1'b0, 32'h0000_6666, 48'h0, 1'b1, 1'b0, 8'h04);
    idle(5);
    chk_regs("upd_short", 1'b1, 32'h0000_1234, 48'hA1B2C3D4E5F6, 1'b1, 64'd1);

    // Foreign-dmac update and a local beacon report back to back: both forwarded
    send_pkt(7, OTHER_MAC, 4'hD, 1'b0, 32'h0000_7777, 48'h0, 1'b1, 1'b1, 8'h05);
    send_pkt(7, LOCAL_MAC, 4'hE, 1'b0, 32'h0000_8888, 48'h0, 1'b1, 1'b1, 8'h06);
    idle(5);
    chk_regs("fwd_beacon", 1'b1, 32'h0000_1234, 48'hA1B2C3D4E5F6, 1'b1, 64'd1);

    // Update immediately followed by a 3-word and a 1-word packet
    send_pkt(7, LOCAL_MAC, 4'hD, 1'b0, 32'h0000_ABCD, 48'h010203040506, 1'b1, 1'b0, 8'h07);
    send_pkt(3, BCAST_MAC, 4'h0, 1'b0, 32'h0, 48'h0, 1'b1, 1'b1, 8'h08);
    send_pkt(1, BCAST_MAC, 4'h0, 1'b0, 32'h0, 48'h0, 1'b1, 1'b1, 8'h09);
    idle(5);
    chk_regs("b2b", 1'b0, 32'h0000_ABCD, 48'h010203040506, 1'b0, 64'd2);

    // Reset while word 4 of an update is on the input
    for (int i = 0; i < 4; i++) begin
      drive(build_word(i, 7, LOCAL_MAC, 16'h88F7, 4'hD, 1'b1, 32'h0000_9999,
                       48'hCAFE_0000_BEEF, 8'h0A), 1'b0, 1'b0, 1'b0);
    end
    in_data = build_word(4, 7, LOCAL_MAC, 16'h88F7, 4'hD, 1'b1, 32'h0000_9999,
                         48'hCAFE_0000_BEEF, 8'h0A);
    rst_n = 1'b0;
    step();
    idle(2);
    chk_regs("midrst", 1'b0, 32'h0, 48'h0, 1'b0, 64'd0);
    rst_n = 1'b1;
    idle(3);
    chk_regs("post_rst", 1'b0, 32'h0, 48'h0, 1'b0, 64'd0);

    // Next good update commits normally
    send_pkt(7, LOCAL_MAC, 4'hD, 1'b1, 32'h0000_0077, 48'h0A0B0C0D0E0F, 1'b1, 1'b0, 8'h0B);
    idle(2);
    chk_regs("upd_after_rst", 1'b1, 32'h0000_0077, 48'h0A0B0C0D0E0F, 1'b1, 64'd1);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
